div_ctrl: RTL and testbench

Sequencing controller for the multi-cycle divider in the E stage. Accepts a DIV/DIVU request from the execute stage and holds the pipeline via stall_div while an iterative radix-2 core runs. Returns quotient and remainder with a one-cycle HI/LO write strobe, and aborts cleanly on a pipeline flush. It drives the stall_divE input of the hazard unit and feeds the hilo_reg write path.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_core.sv | 43 ++++
 rtl/div_ctrl.sv | 128 ++++++++++++
 tb/tb_div_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider controller and its datapath.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Divide-by-zero: every quotient bit is set and the remainder passes the dividend through.
    localparam logic DIV_ZERO_QUOT_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } divState_t;

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 shift-subtract datapath, one quotient bit per step.
// Latency: load then one step per cycle; next-step values are combinational outputs.
// Backpressure: none; the controller gates load/step.
module div_core import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quoNext,
    output logic [WIDTH-1:0] remNext
);

    logic [WIDTH-1:0] remQ;
    logic [WIDTH-1:0] quoQ;
    logic [WIDTH-1:0] divQ;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic             fits;

    // The partial remainder stays below the divisor, so a clear top bit of diff means no borrow.
    always_comb begin
        remShift = {remQ, quoQ[WIDTH-1]};
        diff     = remShift - {1'b0, divQ};
        fits     = ~diff[WIDTH];
        remNext  = fits ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
        quoNext  = {quoQ[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            remQ <= '0;
            quoQ <= dividend;
            divQ <= divisor;
        end else if (step) begin
            remQ <= remNext;
            quoQ <= quoNext;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: holds E stage via stall_div while div_core iterates, then strobes HI/LO.
// Latency: WIDTH+2 cycles (2 for divide-by-zero, or |opa|<|opb| when DIV_EARLY_EXIT_EN is defined).
// Backpressure: stall_div held from acceptance through CALC; flush drops it in the same cycle.
module div_ctrl import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall_div,
    output logic             busy,
    output logic             result_valid,
    output logic             hilo_we,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    divState_t        state;
    logic [CNT_W-1:0] count;
    logic             negQuo;
    logic             negRem;
    logic             busyQ;
    logic             validQ;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic             accept;
    logic             divZero;
    logic             coreLoad;
    logic             coreStep;
    logic [WIDTH-1:0] coreQuo;
    logic [WIDTH-1:0] coreRem;

    always_comb begin
        magA     = (signed_op && opa[WIDTH-1]) ? -opa : opa;
        magB     = (signed_op && opb[WIDTH-1]) ? -opb : opb;
        accept   = (state == IDLE) && start && !flush;
        divZero  = (opb == '0);
        coreLoad = rst && accept && !divZero;
        coreStep = rst && (state == CALC) && !flush;
    end

    assign stall_div    = !flush && (((state == IDLE) && start) || (state == CALC));
    assign busy         = busyQ;
    assign result_valid = validQ;
    assign hilo_we      = validQ && !flush;

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .load     (coreLoad),
        .step     (coreStep),
        .dividend (magA),
        .divisor  (magB),
        .quoNext  (coreQuo),
        .remNext  (coreRem)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            negQuo    <= 1'b0;
            negRem    <= 1'b0;
            busyQ     <= 1'b0;
            validQ    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            validQ <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (accept) begin
                        if (divZero) begin
                            quotient  <= {WIDTH{DIV_ZERO_QUOT_FILL}};
                            remainder <= opa;
                            validQ    <= 1'b1;
                            state     <= DONE;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (magA < magB) begin
                            quotient  <= '0;
                            remainder <= opa;
                            validQ    <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            negQuo <= signed_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                            negRem <= signed_op && opa[WIDTH-1];
                            busyQ  <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busyQ <= 1'b0;
                        count <= '0;
                        state <= IDLE;
                    end else if (count == CNT_W'(WIDTH - 1)) begin
                        // Sign fix-up is taken from the final step's combinational result.
                        quotient  <= negQuo ? -coreQuo : coreQuo;
                        remainder <= negRem ? -coreRem : coreRem;
                        busyQ     <= 1'b0;
                        validQ    <= 1'b1;
                        count     <= '0;
                        state     <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    busyQ <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed-vector bench for div_ctrl with a queue scoreboard checked on every result_valid pulse.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        stall_div;
    logic        busy;
    logic        result_valid;
    logic        hilo_we;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   nOps = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 34;
`endif

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_op    (signed_op),
        .flush        (flush),
        .opa          (opa),
        .opb          (opb),
        .stall_div    (stall_div),
        .busy         (busy),
        .result_valid (result_valid),
        .hilo_we      (hilo_we),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got q=%h r=%h expected no pulse", quotient, remainder);
            end else begin
                mon = sb.pop_front();
                chk("quotient", quotient, mon.q);
                chk("remainder", remainder, mon.r);
                chk("hilo_we", {31'b0, hilo_we}, {31'b0, mon.we});
            end
        end
    end

    // Holds start like a stalled pipeline; fd raises flush during the DONE cycle.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] q, input logic [31:0] r, input int lat, input logic fd);
        exp_t e;
        int   cyc;
        int   stalls;
        e.q  = q;
        e.r  = r;
        e.we = ~fd;
        sb.push_back(e);
        nOps++;
        @(negedge clk);
        start = 1'b1; opa = a; opb = b; signed_op = s;
        #1;
        cyc    = 1;
        stalls = (stall_div === 1'b1) ? 1 : 0;
        while (result_valid !== 1'b1 && cyc < 100) begin
            if (fd && cyc == lat - 1) begin
                @(posedge clk);
                #1 flush = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (stall_div === 1'b1) stalls++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("stall_cycles", 32'(stalls), 32'(lat - 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_valid"}, {31'b0, result_valid}, 32'h0);
        chk({tag, "_we"}, {31'b0, hilo_we}, 32'h0);
        chk({tag, "_stall"}, {31'b0, stall_div}, 32'h0);
        chk({tag, "_quot"}, quotient, 32'h0);
        chk({tag, "_rem"}, remainder, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chkIdle("reset");
        start = 1'b1;
        #1 chk("reset_stall_start", {31'b0, stall_div}, 32'h1);
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        runOp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1'b0);
        runOp(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 1'b0);
        runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 34, 1'b0);
        runOp(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 34, 1'b0);
        runOp(32'hFFFFFFFF, 32'd10, 1'b0, 32'h19999999, 32'd5, 34, 1'b0);
        runOp(32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 2, 1'b0);
        runOp(32'hFFFFFFF0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 2, 1'b0);
        runOp(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, SMALL_LAT, 1'b0);
        runOp(32'hFFFFFFFD, 32'd5, 1'b1, 32'd0, 32'hFFFFFFFD, SMALL_LAT, 1'b0);
        runOp(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 34, 1'b1);

        // Flush during the tenth CALC cycle: no result may follow.
        @(negedge clk);
        start = 1'b1; opa = 32'd1000; opb = 32'd10; signed_op = 1'b0;
        repeat (10) @(negedge clk);
        chk("calc_busy", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        #1 chk("flush_stall", {31'b0, stall_div}, 32'h0);
        chk("flush_we", {31'b0, hilo_we}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_idle_stall", {31'b0, stall_div}, 32'h0);
        repeat (40) @(negedge clk);
        runOp(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 1'b0);

        // One-cycle reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; opa = 32'd50; opb = 32'd5; signed_op = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chkIdle("midreset");
        repeat (40) @(negedge clk);
        runOp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1'b0);

        repeat (3) @(negedge clk);
        chk("pulse_count", 32'(pulses), 32'(nOps));
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
